// File: rtl/cache_line_xfer_ctrl.sv
// Owns the 4B memory port for one 64B miss: optional 16-word writeback, then 16-word refill.
// Define CACHE_LINE_XFER_CTRL_CRIT_WORD_EN for critical-word-first refill with crit_val/crit_data.
module cache_line_xfer_ctrl #(
  parameter int unsigned NUM_WORDS       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_val,
  output logic         req_rdy,
  input  logic         req_evict,
  input  logic [31:0]  req_victim_addr,
  input  logic [511:0] req_victim_data,
  input  logic [31:0]  req_refill_addr,
  output logic         resp_val,
  input  logic         resp_rdy,
  output logic [511:0] resp_data,
  output logic         memreq_val,
  input  logic         memreq_rdy,
  output logic [76:0]  memreq_msg,
  input  logic         memresp_val,
  output logic         memresp_rdy,
  input  logic [46:0]  memresp_msg,
`ifdef CACHE_LINE_XFER_CTRL_CRIT_WORD_EN
  output logic         crit_val,
  output logic [31:0]  crit_data,
`endif
  output logic         busy
);
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned LINE_W = 26;
  localparam logic [CNT_W-1:0] WORDS   = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4b_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4b_t;

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   ack_cnt;
  logic [CNT_W-1:0]   issue_nxt;
  logic [CNT_W-1:0]   ack_nxt;
  logic [CNT_W-1:0]   outstanding;
  logic [LINE_W-1:0]  victim_line;
  logic [LINE_W-1:0]  refill_line;
  logic [511:0]       victim_data;
  logic [511:0]       line_buf;
  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   resp_word;
  logic               req_fire;
  logic               resp_fire;
  logic               wr_phase;
  logic               rf_phase;
  mem_req_4b_t        req_msg;
  mem_resp_4b_t       resp;
  logic               unused_bits;
`ifdef CACHE_LINE_XFER_CTRL_CRIT_WORD_EN
  logic [IDX_W-1:0]   crit_word;
`endif

  assign resp      = memresp_msg;
  assign resp_word = resp.opaque[IDX_W-1:0];
  assign req_fire  = memreq_val & memreq_rdy;
  assign resp_fire = memresp_val & memresp_rdy;
  assign issue_nxt = issue_cnt + CNT_W'(req_fire);
  assign ack_nxt   = ack_cnt + CNT_W'(resp_fire);
  assign outstanding = issue_cnt - ack_cnt;
  assign wr_phase  = (state == WB_REQ);
  assign rf_phase  = (state == RF_REQ) || (state == RF_WAIT);
  assign resp_data = line_buf;
  assign unused_bits = ^{resp.msg_type, resp.opaque[7:IDX_W], resp.test, resp.len,
                         req_victim_addr[5:0], req_refill_addr[5:0]};

  // Word index of the next request; refill may start at the critical word and wrap.
  always_comb begin
    req_idx = issue_cnt[IDX_W-1:0];
`ifdef CACHE_LINE_XFER_CTRL_CRIT_WORD_EN
    if (!wr_phase) req_idx = crit_word + issue_cnt[IDX_W-1:0];
`endif
  end

  // Request path depends only on registers, never on memreq_rdy.
  always_comb begin
    req_msg          = '0;
    req_msg.msg_type = wr_phase ? 3'd1 : 3'd0;
    req_msg.opaque   = {4'b0, req_idx};
    req_msg.addr     = {(wr_phase ? victim_line : refill_line), req_idx, 2'b00};
    req_msg.len      = 2'd0;
    req_msg.data     = wr_phase ? victim_data[{req_idx, 5'b0} +: 32] : 32'd0;
  end

  assign memreq_msg = req_msg;
  assign memreq_val = ((state == WB_REQ) || (state == RF_REQ)) &&
                      (issue_cnt < WORDS) && (outstanding < MAX_OUT);

`ifdef CACHE_LINE_XFER_CTRL_CRIT_WORD_EN
  assign crit_data = line_buf[{crit_word, 5'b0} +: 32];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      ack_cnt     <= '0;
      victim_line <= '0;
      refill_line <= '0;
      victim_data <= '0;
      line_buf    <= '0;
      req_rdy     <= 1'b1;
      resp_val    <= 1'b0;
      memresp_rdy <= 1'b0;
      busy        <= 1'b0;
`ifdef CACHE_LINE_XFER_CTRL_CRIT_WORD_EN
      crit_word   <= '0;
      crit_val    <= 1'b0;
`endif
    end else begin
      issue_cnt <= issue_nxt;
      ack_cnt   <= ack_nxt;
      // Read responses may return in any order; opaque carries the word slot.
      if (resp_fire && rf_phase) line_buf[{resp_word, 5'b0} +: 32] <= resp.data;
`ifdef CACHE_LINE_XFER_CTRL_CRIT_WORD_EN
      crit_val <= resp_fire && rf_phase && (resp_word == crit_word);
`endif
      case (state)
        IDLE: begin
          if (req_val) begin
            victim_line <= req_victim_addr[31:6];
            refill_line <= req_refill_addr[31:6];
            victim_data <= req_victim_data;
`ifdef CACHE_LINE_XFER_CTRL_CRIT_WORD_EN
            crit_word   <= req_refill_addr[5:2];
`endif
            issue_cnt   <= '0;
            ack_cnt     <= '0;
            state       <= req_evict ? WB_REQ : RF_REQ;
            req_rdy     <= 1'b0;
            busy        <= 1'b1;
            memresp_rdy <= 1'b1;
          end
        end
        WB_REQ:  if (issue_nxt == WORDS) state <= WB_WAIT;
        WB_WAIT: begin
          if (ack_nxt == WORDS) begin
            state     <= RF_REQ;
            issue_cnt <= '0;
            ack_cnt   <= '0;
          end
        end
        RF_REQ:  if (issue_nxt == WORDS) state <= RF_WAIT;
        RF_WAIT: begin
          if (ack_nxt == WORDS) begin
            state       <= DONE;
            resp_val    <= 1'b1;
            memresp_rdy <= 1'b0;
          end
        end
        DONE: begin
          if (resp_rdy) begin
            state    <= IDLE;
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
